alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADD_LAT, 1: settle cycles for add/sub
- MUL_LAT, 3: settle cycles for multiply
- DIV_LAT, 4: settle cycles for divide/modulo
- All latencies SHALL be at least 1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- req_valid, in, 2: per-requester request valid.
- req_ready, out, 2: per-requester accept.
- req_opcode, in, 2x4: per-requester opcode. 0001 add, 0010 sub, 0011 mul, 0100 div, 0101 mod.
- req_a, req_b, in, 2x16: per-requester operands.
- alu_input1, alu_input2, out, 16: operands driven to the shared ALU.
- alu_opcode, out, 4: opcode driven to the shared ALU.
- alu_result, in, 32: ALU result.
- alu_error, in, 2: ALU error. Bit 1 is div/mod-by-0; bit 0 is overflow.
- rsp_valid, out, 1: response valid.
- rsp_ready, in, 1: response accept.
- rsp_id, out, 1: index of the requester being answered.
- rsp_result, out, 32: captured result.
- rsp_error, out, 2: captured error.
- busy, out, 1: high whenever the FSM is not in IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, WAIT, RESP, and FAULT.

REQ-004 In IDLE, req_ready SHALL be one-hot on the round-robin winner among the valid requesters, and all zeros if no requester is valid.
- The winner is the valid requester not granted last.
- A lone valid requester SHALL always win.
- req_ready SHALL be zero in every state other than IDLE.

REQ-005 On accept (req_valid[i] & req_ready[i]), the FSM SHALL:
- register the opcode, operands, and i;
- go to WAIT for a legal opcode;
- go to FAULT for an illegal opcode.

REQ-006 In WAIT, alu_input1, alu_input2, and alu_opcode SHALL hold the registered values, stable for the whole state.
- In all other states these outputs SHALL be zero; opcode 0000 is the ALU ground channel.

REQ-007 The WAIT counter SHALL load the opcode's latency: ADD_LAT for 0001/0010, MUL_LAT for 0011, DIV_LAT for 0100/0101.
- The counter SHALL decrement once per cycle.
- On the cycle the count is 1, alu_result and alu_error SHALL be captured and the FSM SHALL go to RESP.

REQ-008 Accept-to-rsp_valid latency SHALL be LAT+1 cycles, where LAT is the loaded latency.

REQ-009 On entry from WAIT, RESP SHALL assert rsp_valid with rsp_id, rsp_result, and rsp_error held stable until rsp_ready.
- On the handshake the FSM SHALL go to IDLE and the round-robin pointer SHALL record rsp_id.

REQ-010 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest accept is the following cycle.

REQ-011 FAULT SHALL present rsp_valid with rsp_result=0 and rsp_error=2'b11, with no ALU cycle.
- Its handshake behaves as RESP.

REQ-012 When both requesters are continuously valid, grants SHALL alternate 0,1,0,1,...

Reset
REQ-013 While rst_n=0, all outputs SHALL be 0, the state SHALL be IDLE, the counter SHALL be 0, and the round-robin pointer SHALL be 1, so requester 0 wins first.

REQ-014 Reset asserted mid-WAIT or mid-RESP SHALL abort the operation with no response, and rsp_valid SHALL fall asynchronously.

Configuration
REQ-015 Macro ALU_SEQ_DIV0_BYPASS_EN:
- Defined: an accepted 0100/0101 with req_b=0 SHALL go directly to RESP with result 0 and error 2'b10, skipping WAIT. Accept-to-rsp_valid latency SHALL be 1 cycle.
- Undefined: such a request SHALL run the full DIV_LAT WAIT, and the ALU-reported error SHALL be forwarded.

Structure
REQ-016 A shared package alu_pkg SHALL hold:
- the 4-bit opcode constants;
- the error bit positions;
- the FSM state enum;
- the default latency constants.

REQ-017 The round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs req[1:0] and last, and output grant[1:0].

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Req0 add a=3, b=1, ADD_LAT=1, with rsp_ready held high -> rsp_valid 2 cycles after accept, rsp_id=0, result=4, error=00.
- Both requesters valid continuously (req0 mul 5x7, req1 sub 3-1) -> order id0 (35), id1 (2), id0, ..., with mul rsp_valid at accept+4.
- Req1 opcode 1111 -> rsp_valid next cycle, result=0, error=11, with alu_opcode staying 0000.
- Req0 div 9/0:
  - with ALU_SEQ_DIV0_BYPASS_EN defined -> rsp at accept+1, error=10;
  - without it -> rsp at accept+5, carrying alu_error.
- rsp_ready held low for 10 cycles -> rsp_* stable, req_ready=0 throughout, and the next accept no earlier than the cycle after the handshake.
- rst_n pulsed low in the middle of WAIT -> all outputs 0 at once, no response issued, and req0 wins first after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, error bit positions, FSM states and default latencies for the ALU sequencer.
package alu_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned OPND_W = 16;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned ERR_W  = 2;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_MUL = 4'h3;
  localparam logic [OPC_W-1:0] OP_DIV = 4'h4;
  localparam logic [OPC_W-1:0] OP_MOD = 4'h5;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_DIV0 = 1;
  localparam logic [ERR_W-1:0] ERR_DIV0_ONLY = ERR_W'(1 << ERR_DIV0);
  localparam logic [ERR_W-1:0] ERR_FAULT     = ERR_W'((1 << ERR_DIV0) | (1 << ERR_OVF));

  localparam int unsigned DEF_ADD_LAT = 1;
  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned DEF_DIV_LAT = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, FAULT} state_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_req_t;

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD};
  endfunction

  function automatic logic op_is_div(input logic [OPC_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request, shared-ALU and response signals of the ALU sequencer; slave is the sequencer side.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][OPC_W-1:0]  req_opcode;
  logic [NREQ-1:0][OPND_W-1:0] req_a;
  logic [NREQ-1:0][OPND_W-1:0] req_b;
  logic [OPND_W-1:0]           alu_input1;
  logic [OPND_W-1:0]           alu_input2;
  logic [OPC_W-1:0]            alu_opcode;
  logic [RES_W-1:0]            alu_result;
  logic [ERR_W-1:0]            alu_error;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic                        rsp_id;
  logic [RES_W-1:0]            rsp_result;
  logic [ERR_W-1:0]            rsp_error;
  logic                        busy;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_result, alu_error, rsp_ready,
    output req_ready, alu_input1, alu_input2, alu_opcode, rsp_valid, rsp_id,
           rsp_result, rsp_error, busy
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_result, alu_error, rsp_ready,
    input  req_ready, alu_input1, alu_input2, alu_opcode, rsp_valid, rsp_id,
           rsp_result, rsp_error, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the valid requester not granted last wins; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Arbitrates two requesters onto one shared multi-cycle ALU and returns one response at a time.
// Optional ALU_SEQ_DIV0_BYPASS_EN: divide/modulo by zero answered immediately without an ALU cycle.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
  input logic            clk,
  input logic            rst_n,
  alu_sequencer_if.slave bus
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [OPND_W-1:0]  in1_q, in1_d, in2_q, in2_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
  logic [ERR_W-1:0]   rsp_error_q, rsp_error_d;
  logic               busy_q, busy_d;
  logic [NREQ-1:0]    grant;
  logic               sel_id;
  logic               accept;
  alu_req_t           sel_req;

  function automatic logic [CNT_W-1:0] lat_of(input logic [OPC_W-1:0] op);
    if (op == OP_MUL) return CNT_W'(MUL_LAT);
    if (op_is_div(op)) return CNT_W'(DIV_LAT);
    return CNT_W'(ADD_LAT);
  endfunction

  rr_arb2 u_arb (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant)
  );

  // Ready is offered only in IDLE and is forced low while reset is held.
  assign bus.req_ready = (rst_n && (state_q == IDLE)) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel_id        = bus.req_ready[1];
  assign sel_req       = '{opcode: bus.req_opcode[sel_id], a: bus.req_a[sel_id], b: bus.req_b[sel_id]};

  assign bus.alu_input1 = in1_q;
  assign bus.alu_input2 = in2_q;
  assign bus.alu_opcode = op_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.busy       = busy_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_error_d  = rsp_error_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_id_d = sel_id;
          if (!op_legal(sel_req.opcode)) begin
            state_d      = FAULT;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_error_d  = ERR_FAULT;
          end
`ifdef ALU_SEQ_DIV0_BYPASS_EN
          else if (op_is_div(sel_req.opcode) && (sel_req.b == '0)) begin
            state_d      = RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_error_d  = ERR_DIV0_ONLY;
          end
`endif
          else begin
            state_d = WAIT;
            cnt_d   = lat_of(sel_req.opcode);
            in1_d   = sel_req.a;
            in2_d   = sel_req.b;
            op_d    = sel_req.opcode;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = bus.alu_result;
          rsp_error_d  = bus.alu_error;
          in1_d        = '0;
          in2_d        = '0;
          op_d         = OP_NOP;
        end
      end
      RESP, FAULT: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          last_d      = rsp_id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      in1_q        <= '0;
      in2_q        <= '0;
      op_q         <= OP_NOP;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_error_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_error_q  <= rsp_error_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level model plus directed and random traffic.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int unsigned ADD_L = 1;
  localparam int unsigned MUL_L = 3;
  localparam int unsigned DIV_L = 4;
`ifdef ALU_SEQ_DIV0_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer #(.ADD_LAT(ADD_L), .MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU: {error, result} from plain arithmetic.
  function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [33:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    case (op)
      4'd1:    r = {1'b0, s[16], 32'(s)};
      4'd2:    r = {1'b0, (a < b), 32'(a) - 32'(b)};
      4'd3:    r = {2'b00, 32'(a) * 32'(b)};
      4'd4:    r = (b == 16'd0) ? {2'b10, 32'hDEAD_BEEF} : {2'b00, 32'(a / b)};
      4'd5:    r = (b == 16'd0) ? {2'b10, 32'hDEAD_BEEF} : {2'b00, 32'(a % b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign {bus.alu_error, bus.alu_result} = alu_ref(bus.alu_opcode, bus.alu_input1, bus.alu_input2);

  int nchecks, nerrors, cyc, acc_id;
  bit keep_valid;
  // Model of the single outstanding transaction.
  bit m_busy, m_last, m_wait;
  int m_due, m_acc, m_first;
  logic m_id;
  logic [3:0] m_op;
  logic [15:0] m_a, m_b;
  logic [31:0] m_res;
  logic [1:0] m_err;
  int log_id[$];
  int log_lat[$];
  logic [31:0] log_res[$];
  logic [1:0] log_err[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic predict(input int id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [33:0] r;
    int lat;
    m_busy = 1'b1; m_acc = cyc; m_first = -1;
    m_id = id[0]; m_op = op; m_a = a; m_b = b;
    if (op < 4'd1 || op > 4'd5) begin
      lat = 1; m_res = 0; m_err = 2'b11; m_wait = 1'b0;
    end else if (BYPASS && (op == 4'd4 || op == 4'd5) && b == 16'd0) begin
      lat = 1; m_res = 0; m_err = 2'b10; m_wait = 1'b0;
    end else begin
      r = alu_ref(op, a, b);
      m_res = r[31:0]; m_err = r[33:32]; m_wait = 1'b1;
      lat = ((op <= 4'd2) ? ADD_L : (op == 4'd3) ? MUL_L : DIV_L) + 1;
    end
    m_due = cyc + lat;
  endtask

  // One clock: check ready, predict accept/handshake, then check registered outputs.
  task automatic cycle();
    logic [1:0] v, win;
    bit hs, exp_v, in_wait;
    #1;
    v = bus.req_valid;
    win = 2'b00;
    if (!m_busy) win = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
    chk("req_ready", 32'(bus.req_ready), 32'(win));
    hs = m_busy && (cyc >= m_due) && bus.rsp_ready;
    if (hs) begin
      log_id.push_back(int'(bus.rsp_id));
      log_res.push_back(bus.rsp_result);
      log_err.push_back(bus.rsp_error);
      log_lat.push_back(m_first - m_acc);
    end
    acc_id = -1;
    if (win != 2'b00) begin
      acc_id = win[1] ? 1 : 0;
      predict(acc_id, bus.req_opcode[acc_id], bus.req_a[acc_id], bus.req_b[acc_id]);
    end
    @(posedge clk);
    cyc++;
    if (hs) begin
      m_busy = 1'b0;
      m_last = m_id;
    end
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(m_busy));
    exp_v = m_busy && (cyc >= m_due);
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    if (bus.rsp_valid && m_busy && m_first < 0) m_first = cyc;
    if (exp_v) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      chk("rsp_result", bus.rsp_result, m_res);
      chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
    end
    in_wait = m_busy && m_wait && (cyc < m_due);
    chk("alu_opcode", 32'(bus.alu_opcode), in_wait ? 32'(m_op) : 32'd0);
    chk("alu_input1", 32'(bus.alu_input1), in_wait ? 32'(m_a) : 32'd0);
    chk("alu_input2", 32'(bus.alu_input2), in_wait ? 32'(m_b) : 32'd0);
    if (acc_id >= 0 && !keep_valid) bus.req_valid[acc_id] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]  = v;
    bus.req_opcode[i] = op;
    bus.req_a[i]      = a;
    bus.req_b[i]      = b;
  endtask

  task automatic run_rsps(input int n, input int budget);
    int start;
    start = log_id.size();
    for (int k = 0; k < budget && log_id.size() < start + n; k++) cycle();
    chk("rsp_count", 32'(log_id.size() - start), 32'(n));
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last = 1'b1; m_wait = 1'b0; m_due = 0; m_first = -1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_alu_opcode"}, 32'(bus.alu_opcode), 32'd0);
    chk({tag, "_alu_in1"}, 32'(bus.alu_input1), 32'd0);
    chk({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    chk({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    nchecks = 0; nerrors = 0; cyc = 0; keep_valid = 1'b0;
    model_reset();
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b0, 4'd0, 16'd0, 16'd0);
    set_req(1, 1'b0, 4'd0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 4'd1, 16'd5, 16'd5);
    set_req(1, 1'b1, 4'd1, 16'd6, 16'd6);
    #1;
    check_all_zero("reset");
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Add 3+1 from requester 0.
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd1, 16'd3, 16'd1);
    run_rsps(1, 20);
    chk("add_id", 32'(log_id[$]), 32'd0);
    chk("add_res", log_res[$], 32'd4);
    chk("add_err", 32'(log_err[$]), 32'd0);
    chk("add_lat", 32'(log_lat[$]), 32'd2);

    // Illegal opcode from requester 1.
    set_req(1, 1'b1, 4'hF, 16'h1234, 16'h5678);
    run_rsps(1, 10);
    chk("ill_id", 32'(log_id[$]), 32'd1);
    chk("ill_res", log_res[$], 32'd0);
    chk("ill_err", 32'(log_err[$]), 32'd3);
    chk("ill_lat", 32'(log_lat[$]), 32'd1);

    // Both requesters continuously valid: strict alternation starting at 0.
    keep_valid = 1'b1;
    b = log_id.size();
    set_req(0, 1'b1, 4'd3, 16'd5, 16'd7);
    set_req(1, 1'b1, 4'd2, 16'd3, 16'd1);
    run_rsps(4, 60);
    keep_valid = 1'b0;
    bus.req_valid = 2'b00;
    for (int k = 0; k < 4 && b + k < log_id.size(); k++) begin
      chk("alt_id", 32'(log_id[b+k]), 32'(k % 2));
      chk("alt_res", log_res[b+k], (k % 2 == 0) ? 32'd35 : 32'd2);
      chk("alt_lat", 32'(log_lat[b+k]), (k % 2 == 0) ? 32'd4 : 32'd2);
    end

    // Divide by zero.
    set_req(0, 1'b1, 4'd4, 16'd9, 16'd0);
    run_rsps(1, 20);
    chk("div0_lat", 32'(log_lat[$]), BYPASS ? 32'd1 : 32'd5);
    chk("div0_err", 32'(log_err[$]), 32'd2);
    chk("div0_res", log_res[$], BYPASS ? 32'd0 : 32'hDEAD_BEEF);

    // Response stalled for 10 cycles while the other requester waits.
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'd1, 16'd100, 16'd23);
    cycle();
    set_req(1, 1'b1, 4'd2, 16'd50, 16'd8);
    repeat (11) cycle();
    bus.rsp_ready = 1'b1;
    b = log_id.size();
    run_rsps(2, 20);
    if (log_id.size() >= b + 2) begin
      chk("stall_res0", log_res[b], 32'd123);
      chk("stall_id1", 32'(log_id[b+1]), 32'd1);
      chk("stall_res1", log_res[b+1], 32'd42);
    end

    // Reset in the middle of WAIT.
    set_req(0, 1'b1, 4'd3, 16'd6, 16'd7);
    cycle();
    cycle();
    set_req(0, 1'b1, 4'd1, 16'd1, 16'd1);
    set_req(1, 1'b1, 4'd1, 16'd2, 16'd2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_wait");
    @(negedge clk);
    chk("rst_wait_norsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    model_reset();
    b = log_id.size();
    run_rsps(1, 10);
    if (log_id.size() > b) chk("rst_first_winner", 32'(log_id[b]), 32'd0);
    bus.req_valid = 2'b00;

    // Reset while a response is waiting for rsp_ready.
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, 4'd1, 16'd7, 16'd8);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_resp");
    @(negedge clk);
    chk("rst_resp_norsp", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          int r;
          logic [3:0] op;
          r = int'($urandom_range(0, 9));
          op = (r < 8) ? 4'(1 + r % 5) : ((r == 8) ? 4'd0 : 4'($urandom_range(6, 15)));
          set_req(i, 1'b1, op, 16'($urandom), ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom));
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
